chargen_ctrl: RTL and testbench
===============================

# chargen_ctrl

Write-side controller for the character FIFO. When enabled, it generates the RFC 864 chargen pattern and pushes it into the FIFO one character at a time. Lines are rotating 95-character printable-ASCII sequences terminated by CR LF. The block drives the FIFO's active-low write strobe and data input, and stalls on the FIFO's active-low full flag. It sits between system control (enable) and the FIFO; the FIFO read side is untouched.

## Interface
Parameters:
- LINE_LEN, 72: printable characters per line, before CR LF; range 1..255.
- CHAR_LO, 8'h20: first character of the rotating set.
- CHAR_HI, 8'h7E: last character of the rotating set. N = CHAR_HI-CHAR_LO+1, 95 by default.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  generation enable; level-sensitive.
- n_full  in  1  FIFO full flag, active-low (0 = full).
- n_wr  out  1  FIFO write strobe, active-low, registered.
- port_in  out  8  FIFO write data, registered.
- busy  out  1  high whenever state ≠ IDLE.
- line_count  out  16  count of completed lines (LF written), wraps modulo 2^16.

## Operation
- Position state:
  - col, 0..LINE_LEN+1, where LINE_LEN = CR and LINE_LEN+1 = LF.
  - start, 0..N-1: first-character offset of the current line.
  - Character at col < LINE_LEN is CHAR_LO + ((start+col) mod N), computed without a divider: a running index that wraps at N.
- FSM states: IDLE, CHECK, WRITE, GAP.
  - IDLE: n_wr=1. If en=1, go to CHECK.
  - CHECK: n_wr=1.
    - If en=0, go to IDLE.
    - Else if n_full=0, stay in CHECK.
    - Else load port_in with the current character and go to WRITE.
  - WRITE: n_wr=0 for exactly one cycle. Go to GAP.
  - GAP: n_wr=1; advance the position, then go to CHECK.
    - col<LINE_LEN+1: col+1.
    - col=LINE_LEN+1 (LF just written): col=0, start=(start+1) mod N, line_count+1.
- en is honoured only in IDLE and CHECK. A character that has entered WRITE always completes WRITE and GAP.
- Position is retained across en deassertion. Re-enable resumes at the next unwritten character, mid-line included.
- Reset values:
  - state IDLE, n_wr=1, port_in=8'h00, busy=0, line_count=0.
  - col=0, start=0.

## Timing
- Throughput: 3 cycles per character (CHECK, WRITE, GAP) when the FIFO is never full.
- Latency: en sampled high in IDLE at edge k gives CHECK in cycle k+1 and n_wr low in cycle k+2.
- port_in is stable from the WRITE cycle through the following GAP cycle. The FIFO captures it on the edge that ends WRITE.
- GAP exists so that n_full reflects the just-committed write before the next CHECK samples it. The controller must never issue a write while n_full=0.
- Stall: while n_full=0 in CHECK, n_wr stays 1 and port_in holds its previous value. WRITE follows on the cycle after n_full returns to 1.
- Simultaneous en=0 and n_full=0 in CHECK: en wins, go to IDLE.
- Reset mid-operation: the synchronous reset overrides every state. n_wr=1 from the cycle after the rst edge. A WRITE cycle coincident with rst is not suppressed; the system resets the FIFO alongside.
- line_count 16'hFFFF + 1 = 16'h0000.

## Test plan
- Reset: hold rst=1 for 2 cycles with en=1 → n_wr=1, busy=0, line_count=0 throughout; no writes.
- Line 0 with n_full=1 constant:
  - en=1 → first n_wr low 2 cycles after en is sampled, data 0x20.
  - 72 writes 0x20..0x67 follow, then 0x0D, then 0x0A, at 3-cycle spacing.
  - line_count=1; line 1 begins with 0x21.
- Character wrap: run to line 24 → line starts at 0x38, col 70 = 0x7E, col 71 = 0x20. Line 95 starts at 0x20 again with line_count=95.
- Full stall: force n_full=0 for 10 cycles while in CHECK at col 5 → no n_wr pulses and port_in unchanged. Release → WRITE next cycle with the col-5 character (start+5); no character is lost or duplicated.
- Enable drop: deassert en during WRITE of the 10th character (0x29) → that write completes, then IDLE, busy=0, no further pulses. Re-assert → next write is 0x2A.
- Reset mid-line: assert rst in GAP of line 3, col 20 → n_wr=1, line_count=0 next cycle. After release with en=1, the first write is 0x20.

Source files
------------

// File: rtl/chargen_ctrl.sv
// Write-side controller for the character FIFO: streams the rotating printable-ASCII
// chargen pattern (LINE_LEN characters then CR LF per line) through a CHECK/WRITE/GAP handshake.
module chargen_ctrl #(
    parameter int         LINE_LEN = 72,
    parameter logic [7:0] CHAR_LO  = 8'h20,
    parameter logic [7:0] CHAR_HI  = 8'h7E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        n_full,
    output logic        n_wr,
    output logic [7:0]  port_in,
    output logic        busy,
    output logic [15:0] line_count
);

    localparam int N  = int'(CHAR_HI) - int'(CHAR_LO) + 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(LINE_LEN + 2);

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] COL_CR   = CW'(LINE_LEN);
    localparam logic [CW-1:0] COL_LF   = CW'(LINE_LEN + 1);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, GAP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [IW-1:0] r_start;
    logic [IW-1:0] r_idx;
    logic          r_n_wr;
    logic [7:0]    r_port_in;
    logic [15:0]   r_line_count;

    logic [7:0]    w_char;
    logic [IW-1:0] w_idx_inc;
    logic [IW-1:0] w_start_inc;
    logic          w_load;
    logic          w_advance;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // en is only looked at in IDLE/CHECK, so a character entering WRITE always finishes GAP.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE:  if (en) w_state_nxt = CHECK;
            CHECK: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (n_full) begin
                    w_state_nxt = WRITE;
                    w_load      = 1'b1;
                end
            end
            WRITE: w_state_nxt = GAP;
            GAP: begin
                w_state_nxt = CHECK;
                w_advance   = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_idx tracks (start+col) mod N incrementally, avoiding a divider.
    always_comb begin
        w_idx_inc   = (r_idx   == IDX_LAST) ? '0 : r_idx   + 1'b1;
        w_start_inc = (r_start == IDX_LAST) ? '0 : r_start + 1'b1;
        if (r_col == COL_CR)      w_char = 8'h0D;
        else if (r_col == COL_LF) w_char = 8'h0A;
        else                      w_char = CHAR_LO + 8'(r_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_wr       <= 1'b1;
            r_port_in    <= 8'h00;
            r_col        <= '0;
            r_start      <= '0;
            r_idx        <= '0;
            r_line_count <= 16'h0000;
        end else begin
            r_n_wr <= (w_state_nxt != WRITE);
            if (w_load) r_port_in <= w_char;
            if (w_advance) begin
                if (r_col == COL_LF) begin
                    r_col        <= '0;
                    r_start      <= w_start_inc;
                    r_idx        <= w_start_inc;
                    r_line_count <= r_line_count + 16'd1;
                end else begin
                    r_col <= r_col + 1'b1;
                    if (r_col < COL_CR) r_idx <= w_idx_inc;
                end
            end
        end
    end

    assign n_wr       = r_n_wr;
    assign port_in    = r_port_in;
    assign busy       = (r_state != IDLE);
    assign line_count = r_line_count;

endmodule

// File: tb/tb_chargen_ctrl.sv
// Scoreboard bench for chargen_ctrl: stimulus queues expected characters, a negedge
// monitor pops one per write strobe; directed checks cover latency, stalls, en drop and reset.
module tb_chargen_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        n_full;
    logic        n_wr;
    logic [7:0]  port_in;
    logic        busy;
    logic [15:0] line_count;

    chargen_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .n_full     (n_full),
        .n_wr       (n_wr),
        .port_in    (port_in),
        .busy       (busy),
        .line_count (line_count)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         wr_cnt   = 0;
    int         prev_cyc = -1;
    bit         chk_spacing = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] wr_data [0:8191];
    int         wr_cyc  [0:8191];
    int         model_w = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected character for the w-th write since reset (72 printable + CR + LF per line).
    function automatic logic [7:0] exp_char(input int w);
        int line = w / 74;
        int col  = w % 74;
        if (col == 72) return 8'h0D;
        if (col == 73) return 8'h0A;
        return 8'(32 + ((line % 95) + col) % 95);
    endfunction

    always @(negedge clk) begin
        if (!chk_spacing) prev_cyc = -1;
        if (n_wr === 1'b0) begin
            wr_data[wr_cnt] = port_in;
            wr_cyc[wr_cnt]  = cyc;
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else                   chk("wr_data", int'(port_in), int'(exp_q.pop_front()));
            if (chk_spacing && prev_cyc >= 0) chk("wr_spacing", cyc - prev_cyc, 3);
            prev_cyc = cyc;
            wr_cnt++;
        end
    end

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_char(model_w));
            model_w++;
        end
    endtask

    task automatic wait_wr(input int target, input int budget);
        int k = 0;
        while (wr_cnt < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (wr_cnt < target) chk("wait_timeout", wr_cnt, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog wr_cnt=%0d", wr_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int base;
        rst = 1'b1; en = 1'b1; n_full = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("rst_n_wr", n_wr, 1);
            chk("rst_busy", busy, 0);
            chk("rst_line_count", line_count, 0);
        end
        rst = 1'b0; en = 1'b0;
        @(negedge clk); #1;

        // line 0 with latency and 3-cycle spacing, continuing through the character wrap
        en = 1'b1; c0 = cyc; chk_spacing = 1'b1;
        push_exp(74);
        @(negedge clk); #1;
        chk("check_busy", busy, 1);
        chk("check_n_wr", n_wr, 1);
        wait_wr(74, 300);
        push_exp(95 * 74 + 1 - 74);
        chk("first_wr_latency", wr_cyc[0], c0 + 2);
        chk("line0_col0", wr_data[0], 8'h20);
        chk("line0_col71", wr_data[71], 8'h67);
        chk("line0_cr", wr_data[72], 8'h0D);
        chk("line0_lf", wr_data[73], 8'h0A);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("line_count_1", line_count, 1);
        wait_wr(95 * 74 + 1, 22000);
        en = 1'b0; chk_spacing = 1'b0;
        chk("line_count_95", line_count, 95);
        chk("line1_col0", wr_data[74], 8'h21);
        chk("line24_col0", wr_data[24 * 74], 8'h38);
        chk("line24_col70", wr_data[24 * 74 + 70], 8'h7E);
        chk("line24_col71", wr_data[24 * 74 + 71], 8'h20);
        chk("line95_col0", wr_data[95 * 74], 8'h20);
        repeat (6) @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst2_line_count", line_count, 0);
        chk("rst2_busy", busy, 0);
        rst = 1'b0; model_w = 0; base = wr_cnt;

        // enable drop during the WRITE of the 10th character
        en = 1'b1;
        push_exp(10);
        wait_wr(base + 10, 100);
        en = 1'b0;
        chk("endrop_10th", wr_data[base + 9], 8'h29);
        repeat (8) @(negedge clk);
        #1;
        chk("endrop_busy", busy, 0);
        chk("endrop_no_writes", wr_cnt, base + 10);
        en = 1'b1;
        push_exp(1);
        wait_wr(base + 11, 20);
        chk("reenable_char", wr_data[base + 10], 8'h2A);

        // FIFO full stall in CHECK at line 1 col 5
        push_exp(79 - 11);
        wait_wr(base + 79, 400);
        n_full = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("stall_no_writes", wr_cnt, base + 79);
        chk("stall_port_in", port_in, 8'h25);
        chk("stall_n_wr", n_wr, 1);
        chk("stall_busy", busy, 1);
        push_exp(1);
        c0 = cyc;
        n_full = 1'b1;
        wait_wr(base + 80, 10);
        chk("stall_release_cyc", wr_cyc[base + 79], c0 + 1);
        chk("stall_release_char", wr_data[base + 79], 8'h26);

        // reset in GAP of line 3 col 20
        push_exp(243 - 80);
        wait_wr(base + 243, 800);
        chk("pre_rst_line_count", line_count, 3);
        chk("line3_col20", wr_data[base + 242], 8'h37);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midrst_n_wr", n_wr, 1);
        chk("midrst_line_count", line_count, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0; model_w = 0;
        push_exp(1);
        wait_wr(base + 244, 20);
        chk("post_rst_char", wr_data[base + 243], 8'h20);
        en = 1'b0;
        repeat (6) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
